// File: rtl/pipe_valid_chain.sv
// pipe_valid_chain: parametrised in-order pipeline skeleton.
// STAGES payload registers linked by the valid / allowin / ready_go handshake.
// Also provides a per-stage flush that kills a stage and every younger stage,
// an occupancy tap and a wrapping retirement counter.
//
// Handshake semantics (both ends and between stages):
//   A payload moves from stage i-1 into stage i on a rising edge exactly when
//   go_{i-1} (the source is valid, has finished its work and is not killed) and
//   allowin_i (stage i is empty or is itself moving on this edge) are both high
//   in the cycle before that edge. At the input, go_{-1} = in_valid & ~kill_0
//   and the producer's ready is in_allowin. At the output, out_valid is go of the
//   last stage and the consumer's ready is out_allowin. Valid never depends on
//   ready from the same side, and ready may depend on valid.
module pipe_valid_chain #(
  parameter int STAGES = 5,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           in_valid,
  input  logic [DATA_W-1:0]              in_bus,
  output logic                           in_allowin,
  input  logic [STAGES-1:0]              stage_ready_go,
  input  logic [STAGES-1:0]              flush,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_bus,
  input  logic                           out_allowin,
  output logic [STAGES-1:0]              stage_valid,
  output logic [STAGES*DATA_W-1:0]       stage_bus,
  output logic [$clog2(STAGES+1)-1:0]    occupancy,
  output logic [CNT_W-1:0]               retired_cnt
);

  localparam int OCC_W = $clog2(STAGES+1);

  // Pipeline state: stage 0 is youngest, stage STAGES-1 is oldest.
  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][DATA_W-1:0] bus_q, bus_d;
  logic [CNT_W-1:0]              retired_cnt_q, retired_cnt_d;

  // Per-stage control terms.
  logic [STAGES-1:0]             kill;
  logic [STAGES-1:0]             go;
  logic [STAGES:0]               allow;
  logic [STAGES-1:0]             src_go;
  logic [STAGES-1:0][DATA_W-1:0] src_bus;
  logic                          out_fire;
  logic [OCC_W-1:0]              occ;

  // Kill propagates from a flushing stage down to every younger stage.
  always_comb begin
    kill = '0;
    kill[STAGES-1] = flush[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      kill[i] = flush[i] | kill[i+1];
    end
  end

  // Allowin ripples back from the consumer; a stage accepts when empty or leaving.
  always_comb begin
    allow = '0;
    allow[STAGES] = out_allowin;
    for (int i = STAGES - 1; i >= 0; i--) begin
      allow[i] = ~valid_q[i] | (stage_ready_go[i] & allow[i+1]);
    end
  end

  // A stage hands off when it holds a finished, non-killed payload.
  always_comb begin
    go = '0;
    for (int i = 0; i < STAGES; i++) begin
      go[i] = valid_q[i] & stage_ready_go[i] & ~kill[i];
    end
  end

  // Source of each stage: the producer for stage 0, the next-younger stage otherwise.
  always_comb begin
    src_go     = '0;
    src_bus    = '0;
    src_go[0]  = in_valid & ~kill[0];
    src_bus[0] = in_bus;
    for (int i = 1; i < STAGES; i++) begin
      src_go[i]  = go[i-1];
      src_bus[i] = bus_q[i-1];
    end
  end

  // Next-state of each stage: kill wins, otherwise load when allowed; payload only on a real transfer.
  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    for (int i = 0; i < STAGES; i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
      end else if (allow[i]) begin
        valid_d[i] = src_go[i];
      end
      if (allow[i] && src_go[i]) begin
        bus_d[i] = src_bus[i];
      end
    end
  end

  // Retirement counter steps on every completed output handshake and wraps naturally.
  always_comb begin
    out_fire      = go[STAGES-1] & out_allowin;
    retired_cnt_d = retired_cnt_q + CNT_W'(out_fire);
  end

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ = occ + OCC_W'(valid_q[i]);
    end
  end

  // All pipeline state; asynchronous reset discards contents immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q       <= '0;
      bus_q         <= '0;
      retired_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      bus_q         <= bus_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign in_allowin  = allow[0] & ~kill[0];
  assign out_valid   = go[STAGES-1];
  assign out_bus     = bus_q[STAGES-1];
  assign stage_valid = valid_q;
  assign stage_bus   = bus_q;
  assign occupancy   = occ;
  assign retired_cnt = retired_cnt_q;

endmodule

// File: doc/pipe_valid_chain.md
Name: pipe_valid_chain

Overview:
- Parametrised in-order pipeline skeleton: STAGES payload registers chained with the valid/allowin/ready_go handshake used by our five-stage CPU.
- Adds what the hand-built stages lack: generic depth and width, a per-stage flush that kills the flushing stage and all younger stages, an occupancy tap and a retirement counter.
- Sits between a producer (fetch side) and a consumer (writeback side). It carries multi-cycle units, MMU/cache pipes and future CPU datapaths.

Parameters:
- STAGES, 5, number of pipeline registers; legal range 2..16.
- DATA_W, 64, payload width per stage; legal range ≥1.
- CNT_W, 32, width of the retirement counter.

Ports:
- clk  input  1  clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  producer offers payload
- in_bus  input  DATA_W  producer payload
- in_allowin  output  1  stage 0 can accept this cycle
- stage_ready_go  input  STAGES  bit i: stage i has finished its work
- flush  input  STAGES  bit k: kill stage k and every stage with index < k
- out_valid  output  1  last stage offers payload
- out_bus  output  DATA_W  last-stage payload
- out_allowin  input  1  consumer accepts
- stage_valid  output  STAGES  per-stage valid, for hazard and forwarding logic
- stage_bus  output  STAGES*DATA_W  per-stage payload, stage i at bits [i*DATA_W +: DATA_W]
- occupancy  output  $clog2(STAGES+1)  number of valid stages
- retired_cnt  output  CNT_W  count of completed output handshakes

Behaviour:
- Stage 0 is youngest and is fed by in_*. Stage STAGES-1 is oldest and drives out_*. Payloads pass through unmodified.
- Reset (resetn=0, asynchronous):
  - all valid_i and bus_i clear to 0; retired_cnt clears to 0.
  - Outputs while held in reset: out_valid=0, out_bus=0, stage_valid=0, occupancy=0, in_allowin=1.
  - Reset asserted mid-operation discards all contents immediately. No handshake completes in that cycle.
- kill_i = OR of flush[j] for all j ≥ i. This is combinational.
- go_i = valid_i & stage_ready_go[i] & ~kill_i.
- allowin_i = ~valid_i | (stage_ready_go[i] & allowin_{i+1}), where allowin_STAGES = out_allowin.
- in_allowin = allowin_0 & ~kill_0. The producer must see no acceptance while a flush is pending.
- Feed into stage 0: go_{-1} = in_valid & ~kill_0.
- out_valid = go_{STAGES-1}; out_bus = bus_{STAGES-1}.
- Per-stage register update at each edge:
  - if kill_i: valid_i ← 0.
  - else if allowin_i: valid_i ← go_{i-1}.
  - bus_i ← source payload (bus_{i-1}, or in_bus for stage 0) when allowin_i & go_{i-1}; otherwise bus_i holds.
- Latency:
  - 1 cycle per stage; minimum in→out is STAGES cycles when all ready_go are high and out_allowin=1.
  - Full throughput is one payload per cycle.
- Backpressure: a stage with ready_go=0 holds its payload. Older stages drain, and younger stages fill until blocked. No payload is lost or duplicated.
- Flush:
  - Flush at k removes the payloads in stages 0..k at the edge.
  - Stage k+1 does not load from stage k in that cycle.
  - Stages > k proceed normally.
  - flush[STAGES-1] also gates out_valid in the same cycle, so no handshake occurs.
  - Several flush bits set at once: the highest set bit dominates.
- Flush with simultaneous in_valid: the input is not accepted (in_allowin=0).
- occupancy = popcount(valid_i). This is combinational from the registers.
- retired_cnt:
  - increments by 1 on each edge where out_valid & out_allowin.
  - wraps modulo 2^CNT_W; the value after 2^CNT_W−1 is 0.
- stage_bus of an invalid stage is don't-care for consumers. The implementation holds the last value.

Test Plan:
- Fill/drain (STAGES=5, all ready_go=1, out_allowin=1): push 0x1..0x8 back to back → out_bus emits 0x1..0x8 on consecutive cycles, first at cycle 5, retired_cnt=8.
- Backpressure: out_allowin=0 after 2 pushes, keep pushing → occupancy reaches 5, in_allowin=0. Release → 0x1..0x5 come out in order with no duplicates.
- Stage stall: stage_ready_go[2]=0 for 3 cycles during streaming → stages 3..4 drain, stages 0..2 hold. Order is preserved, and a bubble appears at the output.
- Flush mid-stream: full pipe holding A(4) B(3) C(2) D(1) E(0), flush=5'b00100 for one cycle → C, D, E discarded; output continues A, B, then the next input.
- Flush on the last stage with out_allowin=1: flush[4] → out_valid=0 that cycle, retired_cnt unchanged, pipe empty next cycle.
- Reset/wrap (CNT_W=4): retire 17 items → retired_cnt=1. Assert resetn=0 mid-stream → stage_valid=0, occupancy=0 and retired_cnt=0 immediately, without waiting for a clock edge.
